// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// blank pattern, scan FSM states and a counter width helper.
package seg7_pkg;

   // All segments off on a common-anode, active-low display
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      ON    = 2'd2
   } state_e;

   // Bits needed for a counter that runs 0 .. n-1 (never less than one bit)
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Bundle between the time-keeping logic (master) and the scan controller
// (slave): BCD time plus display controls in, segment/anode pins out.
interface seg7_scan_ctrl_if #(
   parameter int NUM_DIGITS = 6
);
   logic                      en;
   logic [4*NUM_DIGITS-1:0]   digits_in;
   logic [NUM_DIGITS-1:0]     blink_mask;
   logic                      lz_en;
   logic [6:0]                seg;
   logic [NUM_DIGITS-1:0]     an;
   logic                      frame_start;

   modport master (
      output en, digits_in, blink_mask, lz_en,
      input  seg, an, frame_start
   );

   modport slave (
      input  en, digits_in, blink_mask, lz_en,
      output seg, an, frame_start
   );
endinterface

// File: rtl/seg7_9.sv
// BCD-to-7-segment decoder, active-low, bit order {g,f,e,d,c,b,a}.
// Codes above 9 have no defined glyph; the caller masks them.
module seg7_9
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Glyph lookup for decimal digits
   always_comb begin
      case (bcd)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Each digit slot starts with a blanking gap (all anodes off, segments
// already showing the next digit) followed by the on time. The BCD value
// and blink mask are captured once per frame so a frame never tears.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 6,
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYC    = 50,
   parameter int BLINK_FRAMES = 64
) (
   input logic             clk,
   input logic             rst,
   seg7_scan_ctrl_if.slave bus
);

   localparam int SLOT_W = cnt_w(SCAN_DIV);
   localparam int FRM_W  = cnt_w(BLINK_FRAMES);
   localparam int IDX_W  = cnt_w(NUM_DIGITS);

   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYC - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [FRM_W-1:0]  FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);

   state_e                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [SLOT_W-1:0]         slot_q, slot_d;
   logic [FRM_W-1:0]          frm_q, frm_d;
   logic                      phase_q, phase_d;
   logic                      seen_q, seen_d;
   logic [4*NUM_DIGITS-1:0]   snap_dig_q, snap_dig_d;
   logic [NUM_DIGITS-1:0]     snap_msk_q, snap_msk_d;
   logic [6:0]                seg_q, seg_d;
   logic [NUM_DIGITS-1:0]     an_q, an_d;
   logic                      fs_q, fs_d;

   logic                      frame_go;
   logic [3:0]                sel_bcd;
   logic                      sel_blink;
   logic [6:0]                dec_seg;

   // Scan sequencing, frame snapshot and blink bookkeeping
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      slot_d     = slot_q;
      frm_d      = frm_q;
      phase_d    = phase_q;
      seen_d     = seen_q;
      snap_dig_d = snap_dig_q;
      snap_msk_d = snap_msk_q;
      frame_go   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.en) begin
               state_d  = BLANK;
               idx_d    = '0;
               slot_d   = '0;
               frame_go = 1'b1;
            end
         end
         BLANK: begin
            slot_d = slot_q + SLOT_W'(1);
            if (slot_q == BLANK_LAST) begin
               state_d = ON;
            end
         end
         ON: begin
            if (slot_q == SLOT_LAST) begin
               slot_d  = '0;
               state_d = BLANK;
               if (idx_q == IDX_LAST) begin
                  idx_d    = '0;
                  frame_go = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               slot_d = slot_q + SLOT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Disable wins from any state and forces a fresh frame on return
      if (!bus.en) begin
         state_d  = IDLE;
         idx_d    = '0;
         slot_d   = '0;
         frame_go = 1'b0;
      end

      // The very first frame after reset does not advance the blink timer
      if (frame_go) begin
         snap_dig_d = bus.digits_in;
         snap_msk_d = bus.blink_mask;
         if (!seen_q) begin
            seen_d = 1'b1;
         end else if (frm_q == FRM_LAST) begin
            frm_d   = '0;
            phase_d = ~phase_q;
         end else begin
            frm_d = frm_q + FRM_W'(1);
         end
      end
   end

   // Pick the snapshot digit and blink bit for the digit about to be shown
   always_comb begin
      sel_bcd   = '0;
      sel_blink = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_d == IDX_W'(i)) begin
            sel_bcd   = snap_dig_d[4*i +: 4];
            sel_blink = snap_msk_d[i];
         end
      end
   end

   seg7_9 u_dec (
      .bcd (sel_bcd),
      .seg (dec_seg)
   );

   // Output pins: blanking overrides in priority order, anode for ON only
   always_comb begin
      seg_d = SEG_BLANK;
      an_d  = '1;
      fs_d  = frame_go;
      if (state_d != IDLE) begin
         if (sel_bcd > 4'd9) begin
            seg_d = SEG_BLANK;
         end else if (bus.lz_en && (idx_d == IDX_LAST) && (sel_bcd == 4'd0)) begin
            seg_d = SEG_BLANK;
         end else if (phase_d && sel_blink) begin
            seg_d = SEG_BLANK;
         end else begin
            seg_d = dec_seg;
         end
      end
      if (state_d == ON) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
               an_d[i] = 1'b0;
            end
         end
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         slot_q     <= '0;
         frm_q      <= '0;
         phase_q    <= 1'b0;
         seen_q     <= 1'b0;
         snap_dig_q <= '0;
         snap_msk_q <= '0;
         seg_q      <= SEG_BLANK;
         an_q       <= '1;
         fs_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         slot_q     <= slot_d;
         frm_q      <= frm_d;
         phase_q    <= phase_d;
         seen_q     <= seen_d;
         snap_dig_q <= snap_dig_d;
         snap_msk_q <= snap_msk_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
         fs_q       <= fs_d;
      end
   end

   assign bus.seg         = seg_q;
   assign bus.an          = an_q;
   assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a frame/slot arithmetic reference model.
module tb_seg7_scan_ctrl;

   localparam int ND    = 6;
   localparam int SD    = 8;
   localparam int BC    = 2;
   localparam int BF    = 2;
   localparam int FRAME = ND * SD;

   localparam logic [6:0] SEG_TAB [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   logic clk = 1'b0;
   logic rst = 1'b1;

   seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

   seg7_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .SCAN_DIV     (SD),
      .BLANK_CYC    (BC),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: position in the frame is plain cycle arithmetic
   bit            model_live = 1'b0;
   bit            running    = 1'b0;
   int            run_t      = 0;
   int            nframes    = 0;
   logic [3:0]    m_dig [ND];
   bit            m_msk [ND];
   logic [6:0]    e_seg;
   logic [ND-1:0] e_an;
   bit            e_fs;

   always @(posedge clk) begin
      int pos, d, off, phase;
      logic [3:0] code;
      model_live = 1'b1;
      e_fs  = 1'b0;
      e_an  = '1;
      e_seg = 7'h7F;
      if (rst) begin
         running = 1'b0;
         nframes = 0;
         for (int i = 0; i < ND; i++) begin
            m_dig[i] = '0;
            m_msk[i] = 1'b0;
         end
      end else if (!bus.en) begin
         running = 1'b0;
      end else begin
         if (!running) begin
            running = 1'b1;
            run_t   = 0;
         end else begin
            run_t++;
         end
         pos = run_t % FRAME;
         d   = pos / SD;
         off = pos % SD;
         if (pos == 0) begin
            for (int i = 0; i < ND; i++) begin
               m_dig[i] = bus.digits_in[4*i +: 4];
               m_msk[i] = bus.blink_mask[i];
            end
            nframes++;
            e_fs = 1'b1;
         end
         phase = ((nframes - 1) / BF) % 2;
         code  = m_dig[d];
         if (code > 4'd9)                                  e_seg = 7'h7F;
         else if (bus.lz_en && d == ND-1 && code == 4'd0)  e_seg = 7'h7F;
         else if (phase == 1 && m_msk[d])                  e_seg = 7'h7F;
         else                                              e_seg = SEG_TAB[code];
         if (off >= BC) e_an[d] = 1'b0;
      end
   end

   // Cycle-by-cycle comparison away from the active edge
   always @(negedge clk) begin
      if (model_live) begin
         check("an",          32'(bus.an),          32'(e_an));
         check("seg",         32'(bus.seg),         32'(e_seg));
         check("frame_start", 32'(bus.frame_start), 32'(e_fs));
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bus.en         = 1'b1;
      bus.digits_in  = 24'h123456;
      bus.blink_mask = '0;
      bus.lz_en      = 1'b0;
      rst            = 1'b1;

      // Reset held with enable high
      cycles(3);
      check("rst_an",  32'(bus.an),          32'h3F);
      check("rst_seg", 32'(bus.seg),         32'h7F);
      check("rst_fs",  32'(bus.frame_start), 32'h0);

      // Basic scan of 123456
      rst = 1'b0;
      cycles(1);
      check("scan_fs",   32'(bus.frame_start), 32'h1);
      check("scan_bl_an", 32'(bus.an),         32'h3F);
      check("scan_bl_seg", 32'(bus.seg),       32'b0000010);
      cycles(BC);
      check("scan_on_an", 32'(bus.an),         32'b111110);
      cycles(SD - BC);
      check("scan_d1_an",  32'(bus.an),        32'h3F);
      check("scan_d1_seg", 32'(bus.seg),       32'b0010010);
      cycles(FRAME - SD);
      check("scan_fs2", 32'(bus.frame_start),  32'h1);

      // Input change during digit 2 is held off until the next frame
      cycles(2*SD + 2);
      bus.digits_in = 24'h999999;
      cycles(2*FRAME);

      // Blink on digits 0 and 1, counted from a fresh reset
      rst = 1'b1;
      cycles(1);
      rst            = 1'b0;
      bus.digits_in  = 24'h123456;
      bus.blink_mask = 6'b000011;
      cycles(1);
      check("blink_fs", 32'(bus.frame_start), 32'h1);
      cycles(2*FRAME + BC);
      check("blink_f3_an",  32'(bus.an),  32'b111110);
      check("blink_f3_seg", 32'(bus.seg), 32'h7F);
      cycles(3*FRAME);

      // Leading-zero suppression and invalid code
      bus.blink_mask = '0;
      bus.lz_en      = 1'b1;
      bus.digits_in  = 24'h012345;
      cycles(2*FRAME);
      bus.digits_in  = 24'h112345;
      cycles(2*FRAME);
      bus.digits_in  = 24'h12345A;
      cycles(2*FRAME);
      bus.lz_en      = 1'b0;

      // Enable drop and reset in the middle of digit 3's on time
      rst            = 1'b1;
      bus.digits_in  = 24'h123456;
      bus.blink_mask = 6'h3F;
      cycles(1);
      rst = 1'b0;
      cycles(1);
      cycles(3*SD + BC);
      bus.en = 1'b0;
      cycles(1);
      check("en_drop_an",  32'(bus.an),  32'h3F);
      check("en_drop_seg", 32'(bus.seg), 32'h7F);
      bus.en = 1'b1;
      cycles(1);
      check("en_back_fs", 32'(bus.frame_start), 32'h1);
      cycles(BC);
      check("en_back_an", 32'(bus.an), 32'b111110);
      cycles(FRAME + 3*SD);
      rst = 1'b1;
      cycles(1);
      check("rst_mid_an",  32'(bus.an),  32'h3F);
      check("rst_mid_seg", 32'(bus.seg), 32'h7F);
      rst = 1'b0;
      cycles(1);
      check("rst_back_fs", 32'(bus.frame_start), 32'h1);
      cycles(BC);
      check("rst_back_an",  32'(bus.an),  32'b111110);
      check("rst_back_seg", 32'(bus.seg), 32'b0000010);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0)   bus.digits_in  = 24'($urandom);
         if ($urandom_range(0, 15) == 0)  bus.blink_mask = 6'($urandom);
         if ($urandom_range(0, 31) == 0)  bus.lz_en      = ~bus.lz_en;
         bus.en = ($urandom_range(0, 99) != 0);
         rst    = ($urandom_range(0, 299) == 0);
         cycles(1);
      end
      rst    = 1'b0;
      bus.en = 1'b1;
      cycles(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for the digital clock's common-anode 7-segment display. It shares one active-low BCD-to-segment decoder across NUM_DIGITS digit positions. It snapshots the BCD time value once per frame so the display cannot tear. It also inserts a blanking gap between digits to prevent ghosting, and applies per-digit blink and leading-zero suppression. It sits between the time-keeping counters and the board's segment/anode pins.

Parameters:
NUM_DIGITS, 6, digit positions scanned (HH:MM:SS).
SCAN_DIV, 1000, clk cycles per digit slot (blank plus on time); constraint SCAN_DIV > BLANK_CYC.
BLANK_CYC, 50, clk cycles with all anodes off at the start of each slot; constraint >= 1.
BLINK_FRAMES, 64, frames per blink half-period.

Ports:
clk  in  1  system clock
rst  in  1  reset
en  in  1  scan enable
digits_in  in  4*NUM_DIGITS  packed BCD; digit i = bits [4i+3:4i], digit 0 = least significant
blink_mask  in  NUM_DIGITS  1 = digit blinks
lz_en  in  1  suppress a zero in digit NUM_DIGITS-1
seg  out  7  segments, active-low (1 = off)
an  out  NUM_DIGITS  anode selects, active-low
frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, an=all 1, seg=7'h7F, frame_start=0, idx=0, slot counter=0, frame counter=0, blink_phase=0, snapshot registers=0.
- All outputs are registered.

States:
- IDLE:
  - an=all 1, seg=7'h7F.
  - If en=1, go to BLANK with idx=0.
- BLANK (BLANK_CYC cycles):
  - an=all 1.
  - seg already carries the decoded value for idx, so segments settle before the anode turns on.
  - Then go to ON.
- ON (SCAN_DIV-BLANK_CYC cycles):
  - an[idx]=0, all other anodes=1.
  - Then idx advances and the FSM goes to BLANK.
  - idx wraps from NUM_DIGITS-1 to 0.

Frame start:
- On every clock edge that enters BLANK with idx=0 (from IDLE or by wrap), load digits_in and blink_mask into the snapshot registers.
- frame_start=1 for exactly the following cycle.
- All decoding uses only the snapshot registers; input changes mid-frame are ignored.

Segment value for digit idx, in priority order:
- BCD code 10 to 15: 7'h7F.
- lz_en=1, idx=NUM_DIGITS-1 and code 0: 7'h7F.
- blink_phase=1 and snapshot blink_mask[idx]=1: 7'h7F. The anode still scans normally.
- Otherwise the standard active-low pattern: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Blink:
- The frame counter increments at each frame start after the first one since reset.
- When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- The frame counter and blink_phase are held (not cleared) while the FSM is IDLE; only rst clears them.

Enable and reset boundaries:
- en=0 in any state: next edge goes to IDLE and outputs blank. idx and the slot counter clear.
- Re-enabling always starts a fresh frame at digit 0.
- rst has priority over en at every edge; asserting rst mid-slot blanks outputs on the next edge.

Decomposition:
- Shared package seg7_pkg holds:
  - the SEG_BLANK=7'h7F constant;
  - the FSM state enum (IDLE, BLANK, ON);
  - a width helper for the counters (clog2 of SCAN_DIV and BLINK_FRAMES).
- One sub-module is natural: the combinational BCD-to-segment decoder (the team's existing seg7_9), instantiated once on the snapshot digit selected by idx.
- The blanking overrides are applied in seg7_scan_ctrl, after the decoder output and before the seg register, so no output depends on the decoder's undefined 10 to 15 cases.

Test Plan:
Bench parameters for all scenarios: NUM_DIGITS=6, SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.
1. Reset: hold rst=1 with en=1 for 3 cycles -> an=6'b111111, seg=7'h7F, frame_start=0 throughout.
2. Basic scan: en=1, digits_in=24'h123456 -> frame_start pulse, then:
   - 2 cycles with an=111111 and seg=0000010;
   - 6 cycles with an=111110 and seg=0000010;
   - next slot shows an=111101 and seg=0010010 (digit 5);
   - frame_start repeats every 48 cycles.
3. Snapshot: change digits_in to 24'h999999 during digit 2 -> the rest of the frame still shows 3,2,1; 9s appear only after the next frame_start.
4. Blink: blink_mask=6'b000011 -> frames 1 and 2 show digits 0 and 1 normally; frames 3 and 4 show seg=7'h7F in their slots while an still pulses 111110/111101; other digits are unaffected.
5. Suppression: lz_en=1 with digits_in=24'h012345 -> digit-5 slot seg=7'h7F; digits_in=24'h112345 -> seg=1111001. A code of 4'hA in digit 0 -> seg=7'h7F.
6. Enable/reset mid-scan: drop en during an ON cycle of digit 3 -> next cycle an=111111, seg=7'h7F; raise en -> frame_start and digit 0 next. Repeating this with rst instead of en gives the same blanking, and blink_phase is cleared.
